// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, instruction field positions and width defaults
package alu_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_OP_WIDTH = 4;
  localparam int DEF_CNT_W    = 16;

  localparam int INSTR_W  = 16;
  localparam int IMM_BIT  = 15;
  localparam int FUNC_MSB = 14;
  localparam int FUNC_LSB = 12;
  localparam int RD_MSB   = 11;
  localparam int RD_LSB   = 10;
  localparam int RS1_MSB  = 9;
  localparam int RS1_LSB  = 8;
  localparam int RS2_MSB  = 1;
  localparam int RS2_LSB  = 0;
  localparam int IMM8_MSB = 7;
  localparam int IMM8_LSB = 0;

  typedef enum logic [3:0] {
    ALU_NOP = 4'd0,
    ALU_ADD = 4'd1,
    ALU_SUB = 4'd2,
    ALU_AND = 4'd3,
    ALU_OR  = 4'd4,
    ALU_XOR = 4'd5,
    ALU_SHL = 4'd6,
    ALU_GT  = 4'd7,
    ALU_EQ  = 4'd8
  } alu_op_e;

  // Opcode is the 3-bit func field plus one so that 0 stays reserved for NOP.
  function automatic logic [3:0] func_to_op(input logic [2:0] f);
    return {1'b0, f} + 4'd1;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - instruction, ALU and result signals of the issue controller
interface alu_issue_ctrl_if #(
  parameter int WIDTH    = 8,
  parameter int OP_WIDTH = 4,
  parameter int CNT_W    = 16
);
  logic                in_valid;
  logic                in_ready;
  logic [15:0]         in_instr;
  logic [OP_WIDTH-1:0] alu_op;
  logic [WIDTH-1:0]    alu_op1;
  logic [WIDTH-1:0]    alu_op2;
  logic [WIDTH-1:0]    alu_result;
  logic                res_valid;
  logic                res_ready;
  logic [WIDTH-1:0]    res_data;
  logic [1:0]          res_rd;
  logic [CNT_W-1:0]    retired_cnt;

  // Issue controller side.
  modport master (
    input  in_valid, in_instr, alu_result, res_ready,
    output in_ready, alu_op, alu_op1, alu_op2, res_valid, res_data, res_rd, retired_cnt
  );

  // Fetch / ALU / writeback consumer side.
  modport slave (
    output in_valid, in_instr, alu_result, res_ready,
    input  in_ready, alu_op, alu_op1, alu_op2, res_valid, res_data, res_rd, retired_cnt
  );
endinterface

// File: rtl/alu_issue_regfile.sv
// rtl/alu_issue_regfile.sv - 4-entry register file, two combinational reads, one write
module alu_issue_regfile #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       raddr_a_i,
  input  logic [1:0]       raddr_b_i,
  output logic [WIDTH-1:0] rdata_a_o,
  output logic [WIDTH-1:0] rdata_b_o,
  input  logic             we_i,
  input  logic [1:0]       waddr_i,
  input  logic [WIDTH-1:0] wdata_i
);
  logic [WIDTH-1:0] rf_q [4];

  // Register storage; cleared asynchronously so a reset mid-stream leaves no stale operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) rf_q[i] <= '0;
    end else if (we_i) begin
      rf_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = rf_q[raddr_a_i];
  assign rdata_b_o = rf_q[raddr_b_i];
endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - ALU issue controller: E/W pipeline, operand forwarding, retire counter
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int OP_WIDTH = DEF_OP_WIDTH,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  alu_issue_ctrl_if.master bus
);
  logic             imm;
  logic [2:0]       func;
  logic [1:0]       rd, rs1, rs2;
  logic [WIDTH-1:0] imm8;

  logic [WIDTH-1:0] rf_rdata_a, rf_rdata_b;
  logic [WIDTH-1:0] src1, src2;
  logic             e_adv, in_ready_w, accept, e_retire;

  logic                e_valid_q, e_valid_d;
  logic [OP_WIDTH-1:0] op_q, op_d;
  logic [WIDTH-1:0]    op1_q, op1_d, op2_q, op2_d;
  logic [1:0]          rd_e_q, rd_e_d;
  logic                w_valid_q, w_valid_d;
  logic [WIDTH-1:0]    w_data_q, w_data_d;
  logic [1:0]          res_rd_q, res_rd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  assign imm  = bus.in_instr[IMM_BIT];
  assign func = bus.in_instr[FUNC_MSB:FUNC_LSB];
  assign rd   = bus.in_instr[RD_MSB:RD_LSB];
  assign rs1  = bus.in_instr[RS1_MSB:RS1_LSB];
  assign rs2  = bus.in_instr[RS2_MSB:RS2_LSB];
  assign imm8 = WIDTH'(bus.in_instr[IMM8_MSB:IMM8_LSB]);

  // The E-stage result is written to the RF on the same edge that reads it, hence the forward path.
  alu_issue_regfile #(.WIDTH(WIDTH)) u_rf (
    .clk       (clk),
    .rst       (rst),
    .raddr_a_i (rs1),
    .raddr_b_i (rs2),
    .rdata_a_o (rf_rdata_a),
    .rdata_b_o (rf_rdata_b),
    .we_i      (e_retire),
    .waddr_i   (rd_e_q),
    .wdata_i   (bus.alu_result)
  );

  // Handshake qualifiers and forwarded operand selection.
  always_comb begin
    e_adv      = ~w_valid_q | bus.res_ready;
    in_ready_w = ~e_valid_q | e_adv;
    accept     = bus.in_valid & in_ready_w;
    e_retire   = e_valid_q & e_adv;
    src1       = (e_retire && (rd_e_q == rs1)) ? bus.alu_result : rf_rdata_a;
    src2       = (e_retire && (rd_e_q == rs2)) ? bus.alu_result : rf_rdata_b;
  end

  // Next state of the E and W stages and the retire counter.
  always_comb begin
    e_valid_d = e_valid_q;
    op_d      = op_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    rd_e_d    = rd_e_q;
    w_valid_d = w_valid_q;
    w_data_d  = w_data_q;
    res_rd_d  = res_rd_q;
    cnt_d     = cnt_q;

    if (accept) begin
      e_valid_d = 1'b1;
      op_d      = OP_WIDTH'(func_to_op(func));
      op1_d     = src1;
      op2_d     = imm ? imm8 : src2;
      rd_e_d    = rd;
    end else if (e_adv) begin
      // E drains: the ALU sees NOP, operands keep their last values.
      e_valid_d = 1'b0;
      op_d      = OP_WIDTH'(ALU_NOP);
    end

    if (e_retire) begin
      w_valid_d = 1'b1;
      w_data_d  = bus.alu_result;
      res_rd_d  = rd_e_q;
    end else if (bus.res_ready) begin
      w_valid_d = 1'b0;
    end

    if (w_valid_q && bus.res_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Pipeline and counter registers; reset drops anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_valid_q <= 1'b0;
      op_q      <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      rd_e_q    <= '0;
      w_valid_q <= 1'b0;
      w_data_q  <= '0;
      res_rd_q  <= '0;
      cnt_q     <= '0;
    end else begin
      e_valid_q <= e_valid_d;
      op_q      <= op_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      rd_e_q    <= rd_e_d;
      w_valid_q <= w_valid_d;
      w_data_q  <= w_data_d;
      res_rd_q  <= res_rd_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.in_ready    = in_ready_w;
  assign bus.alu_op      = op_q;
  assign bus.alu_op1     = op1_q;
  assign bus.alu_op2     = op2_q;
  assign bus.res_valid   = w_valid_q;
  assign bus.res_data    = w_data_q;
  assign bus.res_rd      = res_rd_q;
  assign bus.retired_cnt = cnt_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed self-checking bench for alu_issue_ctrl
module tb_alu_issue_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  alu_issue_ctrl_if #(.WIDTH(8), .OP_WIDTH(4), .CNT_W(16)) bus ();

  alu_issue_ctrl #(.WIDTH(8), .OP_WIDTH(4), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference combinational ALU feeding alu_result.
  always_comb begin
    case (bus.alu_op)
      4'd1:    bus.alu_result = bus.alu_op1 + bus.alu_op2;
      4'd2:    bus.alu_result = bus.alu_op1 - bus.alu_op2;
      4'd3:    bus.alu_result = bus.alu_op1 & bus.alu_op2;
      4'd4:    bus.alu_result = bus.alu_op1 | bus.alu_op2;
      4'd5:    bus.alu_result = bus.alu_op1 ^ bus.alu_op2;
      4'd6:    bus.alu_result = bus.alu_op1 << bus.alu_op2[2:0];
      4'd7:    bus.alu_result = {7'd0, bus.alu_op1 > bus.alu_op2};
      4'd8:    bus.alu_result = {7'd0, bus.alu_op1 == bus.alu_op2};
      default: bus.alu_result = 8'd0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [15:0] enc(input logic i, input logic [2:0] f, input logic [1:0] d,
                                      input logic [1:0] s1, input logic [7:0] low);
    return {i, f, d, s1, low};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic [15:0] instr);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_instr  = 16'h0;
    bus.res_ready = 1'b1;

    // Reset state
    tick(); tick();
    chk("rst_res_valid", 32'(bus.res_valid), 32'h0);
    chk("rst_alu_op", 32'(bus.alu_op), 32'h0);
    chk("rst_op1", 32'(bus.alu_op1), 32'h0);
    chk("rst_op2", 32'(bus.alu_op2), 32'h0);
    chk("rst_res_data", 32'(bus.res_data), 32'h0);
    chk("rst_res_rd", 32'(bus.res_rd), 32'h0);
    chk("rst_cnt", 32'(bus.retired_cnt), 32'h0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);

    // 1: addi r1 = r0 + 5
    tick();
    drive(enc(1'b1, 3'd0, 2'd1, 2'd0, 8'h05));
    tick();
    bus.in_valid = 1'b0;
    chk("t1_alu_op", 32'(bus.alu_op), 32'h1);
    chk("t1_op2", 32'(bus.alu_op2), 32'h05);
    tick();
    chk("t1_res_valid", 32'(bus.res_valid), 32'h1);
    chk("t1_res_data", 32'(bus.res_data), 32'h05);
    chk("t1_res_rd", 32'(bus.res_rd), 32'h1);
    tick();
    chk("t1_cnt", 32'(bus.retired_cnt), 32'h1);
    chk("t1_drain", 32'(bus.res_valid), 32'h0);

    // 2: back-to-back RAW: r1 = r1 + 3 (8), then r1 = r1 + r1 (16) via forwarding
    drive(enc(1'b1, 3'd0, 2'd1, 2'd1, 8'h03));
    tick();
    drive(enc(1'b0, 3'd0, 2'd1, 2'd1, 8'h01));
    tick();
    bus.in_valid = 1'b0;
    chk("t2_res_a", 32'(bus.res_data), 32'h08);
    chk("t2_fwd_op1", 32'(bus.alu_op1), 32'h08);
    chk("t2_fwd_op2", 32'(bus.alu_op2), 32'h08);
    tick();
    chk("t2_res_b", 32'(bus.res_data), 32'h10);
    chk("t2_res_b_rd", 32'(bus.res_rd), 32'h1);
    tick();
    chk("t2_cnt", 32'(bus.retired_cnt), 32'h3);

    // 3: wrap: r2 = 0xFF; r2 += 1 -> 0; r3 = r0 - 1 -> 0xFF; r1 = (r2 == r2) -> 1
    drive(enc(1'b1, 3'd0, 2'd2, 2'd0, 8'hFF));
    tick();
    drive(enc(1'b1, 3'd0, 2'd2, 2'd2, 8'h01));
    tick();
    chk("t3_ff", 32'(bus.res_data), 32'hFF);
    drive(enc(1'b1, 3'd1, 2'd3, 2'd0, 8'h01));
    tick();
    chk("t3_wrap0", 32'(bus.res_data), 32'h00);
    drive(enc(1'b0, 3'd7, 2'd1, 2'd2, 8'h02));
    tick();
    bus.in_valid = 1'b0;
    chk("t3_sub_ff", 32'(bus.res_data), 32'hFF);
    chk("t3_sub_rd", 32'(bus.res_rd), 32'h3);
    chk("t3_eq_op", 32'(bus.alu_op), 32'h8);
    tick();
    chk("t3_eq", 32'(bus.res_data), 32'h01);
    chk("t3_eq_rd", 32'(bus.res_rd), 32'h1);
    tick();
    chk("t3_cnt", 32'(bus.retired_cnt), 32'h7);
    chk("t3_idle", 32'(bus.res_valid), 32'h0);

    // 4: backpressure for 5 cycles with in_valid held high
    bus.res_ready = 1'b0;
    drive(enc(1'b1, 3'd0, 2'd1, 2'd0, 8'h11));
    tick();
    chk("t4_ready_1st", 32'(bus.in_ready), 32'h1);
    drive(enc(1'b1, 3'd0, 2'd2, 2'd0, 8'h22));
    tick();
    drive(enc(1'b1, 3'd0, 2'd3, 2'd0, 8'h33));
    for (int i = 0; i < 4; i++) begin
      chk("t4_stall_ready", 32'(bus.in_ready), 32'h0);
      chk("t4_stall_data", 32'(bus.res_data), 32'h11);
      chk("t4_stall_valid", 32'(bus.res_valid), 32'h1);
      tick();
    end
    chk("t4_stall_cnt", 32'(bus.retired_cnt), 32'h7);
    bus.res_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("t4_rel_b", 32'(bus.res_data), 32'h22);
    chk("t4_rel_b_rd", 32'(bus.res_rd), 32'h2);
    chk("t4_rel_cnt", 32'(bus.retired_cnt), 32'h8);
    tick();
    chk("t4_rel_c", 32'(bus.res_data), 32'h33);
    chk("t4_rel_c_rd", 32'(bus.res_rd), 32'h3);
    tick();
    chk("t4_cnt", 32'(bus.retired_cnt), 32'hA);
    chk("t4_idle", 32'(bus.res_valid), 32'h0);

    // 5: asynchronous reset with E and W both occupied
    drive(enc(1'b1, 3'd0, 2'd1, 2'd1, 8'h40));
    tick();
    drive(enc(1'b1, 3'd0, 2'd2, 2'd2, 8'h40));
    tick();
    chk("t5_pre_valid", 32'(bus.res_valid), 32'h1);
    chk("t5_pre_op", 32'(bus.alu_op), 32'h1);
    #2;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk("t5_res_valid", 32'(bus.res_valid), 32'h0);
    chk("t5_alu_op", 32'(bus.alu_op), 32'h0);
    chk("t5_cnt", 32'(bus.retired_cnt), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("t5_no_late", 32'(bus.res_valid), 32'h0);
    drive(enc(1'b0, 3'd0, 2'd0, 2'd1, 8'h02));
    tick();
    bus.in_valid = 1'b0;
    chk("t5_rf_r1", 32'(bus.alu_op1), 32'h0);
    chk("t5_rf_r2", 32'(bus.alu_op2), 32'h0);
    tick();
    chk("t5_sum", 32'(bus.res_data), 32'h0);
    tick();
    chk("t5_cnt_after", 32'(bus.retired_cnt), 32'h1);

    // 6: counter wrap after 65535 retires
    drive(enc(1'b1, 3'd0, 2'd0, 2'd0, 8'h01));
    for (int i = 0; i < 65534; i++) tick();
    bus.in_valid = 1'b0;
    tick(); tick();
    chk("t6_cnt_max", 32'(bus.retired_cnt), 32'hFFFF);
    chk("t6_idle", 32'(bus.res_valid), 32'h0);
    drive(enc(1'b1, 3'd0, 2'd0, 2'd0, 8'h01));
    tick();
    bus.in_valid = 1'b0;
    tick(); tick();
    chk("t6_cnt_wrap", 32'(bus.retired_cnt), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
